// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 game-key controller: key indices, scancodes
// and the prefix-tracking FSM state type.
package ps2_key_pkg;

    localparam int NUM_KEYS  = 6;
    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_JUMP  = 4;
    localparam int KEY_START = 5;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_BAT = 8'hAA;

    // Non-extended (set 2) codes
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;

    // E0-prefixed arrow codes
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational scancode-to-key lookup; the ext flag selects the E0 table.
module ps2_scancode_map
    import ps2_key_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic       hit,
    output logic [2:0] key_idx
);

    always_comb begin
        hit     = 1'b0;
        key_idx = 3'd0;
        if (ext) begin
            case (code)
                SC_ARROW_LEFT:  begin hit = 1'b1; key_idx = 3'(KEY_LEFT);  end
                SC_ARROW_RIGHT: begin hit = 1'b1; key_idx = 3'(KEY_RIGHT); end
                SC_ARROW_UP:    begin hit = 1'b1; key_idx = 3'(KEY_UP);    end
                SC_ARROW_DOWN:  begin hit = 1'b1; key_idx = 3'(KEY_DOWN);  end
                default:        begin hit = 1'b0; key_idx = 3'd0;          end
            endcase
        end else begin
            case (code)
                SC_SPACE: begin hit = 1'b1; key_idx = 3'(KEY_JUMP);  end
                SC_ENTER: begin hit = 1'b1; key_idx = 3'(KEY_START); end
                SC_A:     begin hit = 1'b1; key_idx = 3'(KEY_LEFT);  end
                SC_D:     begin hit = 1'b1; key_idx = 3'(KEY_RIGHT); end
                SC_W:     begin hit = 1'b1; key_idx = 3'(KEY_UP);    end
                SC_S:     begin hit = 1'b1; key_idx = 3'(KEY_DOWN);  end
                default:  begin hit = 1'b0; key_idx = 3'd0;          end
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_controller.sv
// Turns the PS/2 scancode byte stream into held levels and press/release
// pulses for six game keys, tracking E0/F0 prefixes with a timeout.
module ps2_key_controller
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 650_000,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                byte_valid,
    input  logic [7:0]          byte_in,
    input  logic                clear,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_released,
    output logic                prefix_err,
    output state_t              state_dbg
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  ext_ctx;
    logic                  map_hit;
    logic [2:0]            map_idx;
    logic [NUM_KEYS-1:0]   key_mask;
    logic [NUM_KEYS-1:0]   held_nxt;
    logic                  is_prefix;

    assign state_dbg = state;
    assign ext_ctx   = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign is_prefix = (byte_in == SC_EXT) || (byte_in == SC_BRK);

    ps2_scancode_map u_map (
        .code    (byte_in),
        .ext     (ext_ctx),
        .hit     (map_hit),
        .key_idx (map_idx)
    );

    assign key_mask = map_hit ? (NUM_KEYS'(1) << map_idx) : '0;

    // Next held vector; clear discards any coincident byte.
    always_comb begin
        held_nxt = key_held;
        if (clear) begin
            held_nxt = '0;
        end else if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (byte_in == SC_BAT)
                        held_nxt = '0;
                    else if (!is_prefix)
                        held_nxt = key_held | key_mask;
                end
                ST_EXT: begin
                    if (!is_prefix)
                        held_nxt = key_held | key_mask;
                end
                ST_BRK, ST_EXT_BRK: held_nxt = key_held & ~key_mask;
                default:            held_nxt = key_held;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            key_held     <= '0;
            key_pressed  <= '0;
            key_released <= '0;
            prefix_err   <= 1'b0;
        end else begin
            key_held     <= held_nxt;
            key_pressed  <= held_nxt & ~key_held;
            key_released <= key_held & ~held_nxt;
            prefix_err   <= 1'b0;
            if (clear) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (byte_valid) begin
                // A byte arriving on the expiry cycle is still decoded.
                cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (byte_in == SC_EXT)      state <= ST_EXT;
                        else if (byte_in == SC_BRK) state <= ST_BRK;
                        else                        state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (byte_in == SC_BRK)      state <= ST_EXT_BRK;
                        else if (byte_in == SC_EXT) state <= ST_EXT;
                        else                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (cnt == CNT_LAST) begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    prefix_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench for ps2_key_controller: expected output vectors are
// queued as each cycle is driven and compared after the following edge.
module tb_ps2_key_controller;
    import ps2_key_pkg::*;

    localparam int T = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         clear = 1'b0;
    logic [5:0]   key_held, key_pressed, key_released;
    logic         prefix_err;
    state_t       state_dbg;

    logic [18:0]  exp_q[$];
    logic [5:0]   model_held = 6'b0;
    int           n_cmp = 0;
    int           n_err = 0;

    ps2_key_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .clear        (clear),
        .key_held     (key_held),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .prefix_err   (prefix_err),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle; expected output is held vector plus derived edges.
    task automatic step(input string tag, input logic v, input logic [7:0] b,
                        input logic clr, input logic [5:0] exp_held);
        logic [18:0] e;
        logic [18:0] got;
        @(negedge clk);
        byte_valid = v;
        byte_in    = b;
        clear      = clr;
        exp_q.push_back({exp_held, exp_held & ~model_held, model_held & ~exp_held, 1'b0});
        model_held = exp_held;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        clear      = 1'b0;
        got = {key_held, key_pressed, key_released, prefix_err};
        e   = exp_q.pop_front();
        check_val(tag, 32'(got), 32'(e));
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic [5:0] exp_held);
        step(tag, 1'b1, b, 1'b0, exp_held);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b0, model_held);
    endtask

    initial begin
        int waited;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", 32'({key_held, key_pressed, key_released, prefix_err}), 32'd0);
        check_val("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // 1: space make / break
        send("t1_make_jump", 8'h29, 6'b010000);
        idle("t1_pulse_drop", 1);
        send("t1_brk_prefix", 8'hF0, 6'b010000);
        idle("t1_gap", $urandom_range(0, 3));
        send("t1_break_jump", 8'h29, 6'b000000);
        idle("t1_rel_drop", 1);

        // 2: extended left, back-to-back strobes, shared bit with A
        send("t2_e0", 8'hE0, 6'b000000);
        send("t2_make_left", 8'h6B, 6'b000001);
        send("t2_e0b", 8'hE0, 6'b000001);
        send("t2_f0", 8'hF0, 6'b000001);
        send("t2_break_left", 8'h6B, 6'b000000);
        idle("t2_gap", $urandom_range(1, 3));
        send("t2_make_a", 8'h1C, 6'b000001);
        send("t2_e0c", 8'hE0, 6'b000001);
        send("t2_f0c", 8'hF0, 6'b000001);
        send("t2_break_arrow", 8'h6B, 6'b000000);

        // 3: typematic repeat of W
        for (int i = 0; i < 5; i++) begin
            send("t3_repeat_up", 8'h1D, 6'b000100);
            idle("t3_gap", $urandom_range(0, 2));
        end
        send("t3_f0", 8'hF0, 6'b000100);
        send("t3_break_up", 8'h1D, 6'b000000);

        // 4: prefix timeout
        send("t4_e0", 8'hE0, 6'b000000);
        check_val("t4_state_ext", 32'(state_dbg), 32'(ST_EXT));
        waited = 0;
        for (int i = 1; i <= 2 * T; i++) begin
            @(posedge clk);
            #1;
            waited = i;
            if (prefix_err) break;
        end
        check_val("t4_timeout_cycles", 32'(waited), 32'(T));
        check_val("t4_err_pulse", 32'(prefix_err), 32'd1);
        check_val("t4_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        idle("t4_err_drop", 1);
        send("t4_74_unmapped", 8'h74, 6'b000000);

        // 5: clear beats a coincident byte
        send("t5_make_left", 8'h1C, 6'b000001);
        send("t5_make_jump", 8'h29, 6'b010001);
        send("t5_make_start", 8'h5A, 6'b110001);
        step("t5_clear", 1'b1, 8'h23, 1'b1, 6'b000000);
        idle("t5_after", 1);

        // 6: BAT release-all, then reset mid-sequence
        send("t6_make_right", 8'h23, 6'b000010);
        send("t6_make_down", 8'h1B, 6'b001010);
        send("t6_bat", 8'hAA, 6'b000000);
        send("t6_hold_up", 8'h1D, 6'b000100);
        send("t6_e0", 8'hE0, 6'b000100);
        send("t6_f0", 8'hF0, 6'b000100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("t6_rst_outputs", 32'({key_held, key_pressed, key_released, prefix_err}), 32'd0);
        check_val("t6_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        model_held = 6'b0;
        send("t6_6b_nonext", 8'h6B, 6'b000000);
        send("t6_make_s", 8'h1B, 6'b001000);

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
